// File: rtl/collision_manager.sv
// Frame-synchronous collision controller: latches pixel hits during a frame, evaluates them
// at each frame boundary, and sequences lives, freeze, invulnerability and game over.
module collision_manager #(
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned LIVES_W       = 3,
    parameter int unsigned FREEZE_FRAMES = 60,
    parameter int unsigned INVULN_FRAMES = 120,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               bubbleHitChar,
    input  logic               arrowHitBubble,
    input  logic               restart,
    output logic               popBubble,
    output logic               arrowRetract,
    output logic               lifeLost,
    output logic [LIVES_W-1:0] lives,
    output logic               freeze,
    output logic               invulnerable,
    output logic               gameOver
);

    localparam logic [LIVES_W-1:0] LIVES_RST   = LIVES_W'(LIVES_INIT);
    localparam logic [LIVES_W-1:0] LIVES_ONE   = LIVES_W'(1);
    localparam logic [CNT_W-1:0]   FREEZE_LOAD = CNT_W'(FREEZE_FRAMES);
    localparam logic [CNT_W-1:0]   INVULN_LOAD = CNT_W'(INVULN_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_FREEZE    = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [CNT_W-1:0]   freeze_cnt_q, freeze_cnt_d;
    logic [CNT_W-1:0]   invuln_cnt_q, invuln_cnt_d;
    logic               char_latch_q, char_latch_d;
    logic               arrow_latch_q, arrow_latch_d;
    logic               pop_q, pop_d;
    logic               lost_q, lost_d;
    logic               freeze_q, freeze_d;
    logic               invuln_q, invuln_d;
    logic               game_over_q, game_over_d;
    logic               eff_char_c, eff_arrow_c;

    // State and output registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_PLAY;
            lives_q       <= LIVES_RST;
            freeze_cnt_q  <= '0;
            invuln_cnt_q  <= '0;
            char_latch_q  <= 1'b0;
            arrow_latch_q <= 1'b0;
            pop_q         <= 1'b0;
            lost_q        <= 1'b0;
            freeze_q      <= 1'b0;
            invuln_q      <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            freeze_cnt_q  <= freeze_cnt_d;
            invuln_cnt_q  <= invuln_cnt_d;
            char_latch_q  <= char_latch_d;
            arrow_latch_q <= arrow_latch_d;
            pop_q         <= pop_d;
            lost_q        <= lost_d;
            freeze_q      <= freeze_d;
            invuln_q      <= invuln_d;
            game_over_q   <= game_over_d;
        end
    end

    // Next-state, frame evaluation and registered output decode
    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        freeze_cnt_d  = freeze_cnt_q;
        invuln_cnt_d  = invuln_cnt_q;
        char_latch_d  = 1'b0;
        arrow_latch_d = 1'b0;
        pop_d         = 1'b0;
        lost_d        = 1'b0;
        eff_char_c    = char_latch_q | bubbleHitChar;
        eff_arrow_c   = arrow_latch_q | arrowHitBubble;

        if (restart) begin
            state_d      = ST_PLAY;
            lives_d      = LIVES_RST;
            freeze_cnt_d = '0;
            invuln_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_PLAY: begin
                    if (startOfFrame) begin
                        pop_d = eff_arrow_c;
                        // Invulnerability is judged on the count held during the ending frame
                        if (invuln_cnt_q != '0) begin
                            invuln_cnt_d = invuln_cnt_q - CNT_ONE;
                        end else if (eff_char_c && (lives_q != '0)) begin
                            lost_d  = 1'b1;
                            lives_d = lives_q - LIVES_ONE;
                            if (lives_q == LIVES_ONE) begin
                                state_d = ST_GAME_OVER;
                            end else begin
                                state_d      = ST_FREEZE;
                                freeze_cnt_d = FREEZE_LOAD;
                            end
                        end
                    end else begin
                        char_latch_d  = eff_char_c;
                        arrow_latch_d = eff_arrow_c;
                    end
                end
                ST_FREEZE: begin
                    if (startOfFrame) begin
                        // A load of 0 or 1 both leave on the first boundary
                        if (freeze_cnt_q <= CNT_ONE) begin
                            state_d      = ST_PLAY;
                            freeze_cnt_d = '0;
                            invuln_cnt_d = INVULN_LOAD;
                        end else begin
                            freeze_cnt_d = freeze_cnt_q - CNT_ONE;
                        end
                    end
                end
                ST_GAME_OVER: begin
                    state_d = ST_GAME_OVER;
                end
                default: begin
                    state_d = ST_PLAY;
                end
            endcase
        end

        freeze_d    = (state_d != ST_PLAY);
        game_over_d = (state_d == ST_GAME_OVER);
        invuln_d    = (invuln_cnt_d != '0);
    end

    assign popBubble    = pop_q;
    assign arrowRetract = pop_q;
    assign lifeLost     = lost_q;
    assign lives        = lives_q;
    assign freeze       = freeze_q;
    assign invulnerable = invuln_q;
    assign gameOver     = game_over_q;

endmodule

// File: tb/tb_collision_manager.sv
// Bench for collision_manager: vector table, directed frame sequences and random traffic
// checked against a frame-level game model.
module tb_collision_manager;

    localparam int unsigned LIVES_INIT    = 3;
    localparam int unsigned LIVES_W       = 3;
    localparam int unsigned FREEZE_FRAMES = 60;
    localparam int unsigned INVULN_FRAMES = 120;
    localparam int unsigned CNT_W         = 8;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame, bubbleHitChar, arrowHitBubble, restart;
    logic               popBubble, arrowRetract, lifeLost;
    logic [LIVES_W-1:0] lives;
    logic               freeze, invulnerable, gameOver;

    int tests_run    = 0;
    int tests_failed = 0;

    collision_manager #(
        .LIVES_INIT   (LIVES_INIT),
        .LIVES_W      (LIVES_W),
        .FREEZE_FRAMES(FREEZE_FRAMES),
        .INVULN_FRAMES(INVULN_FRAMES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .bubbleHitChar (bubbleHitChar),
        .arrowHitBubble(arrowHitBubble),
        .restart       (restart),
        .popBubble     (popBubble),
        .arrowRetract  (arrowRetract),
        .lifeLost      (lifeLost),
        .lives         (lives),
        .freeze        (freeze),
        .invulnerable  (invulnerable),
        .gameOver      (gameOver)
    );

    always #5 clk = ~clk;

    // Game model: mode 0 = playing, 1 = frozen, 2 = game over
    int m_lives, m_mode, m_frozen_frames, m_inv_left;
    bit m_char_seen, m_arrow_seen, e_pop, e_lost;

    function automatic void model_reset();
        m_lives = LIVES_INIT; m_mode = 0; m_frozen_frames = 0; m_inv_left = 0;
        m_char_seen = 0; m_arrow_seen = 0; e_pop = 0; e_lost = 0;
    endfunction

    function automatic void model_clock(bit sof, bit bhc, bit ahb, bit rst);
        bit ch, ar;
        int freeze_len;
        e_pop = 0; e_lost = 0;
        if (rst) begin
            model_reset();
            return;
        end
        freeze_len = (FREEZE_FRAMES == 0) ? 1 : int'(FREEZE_FRAMES);
        if (m_mode == 0) begin
            ch = m_char_seen | bhc;
            ar = m_arrow_seen | ahb;
            if (sof) begin
                e_pop = ar;
                if (m_inv_left > 0) m_inv_left--;
                else if (ch && m_lives > 0) begin
                    e_lost = 1;
                    m_lives--;
                    if (m_lives == 0) m_mode = 2;
                    else begin m_mode = 1; m_frozen_frames = 0; end
                end
                m_char_seen = 0; m_arrow_seen = 0;
            end else begin
                m_char_seen = ch; m_arrow_seen = ar;
            end
        end else if (m_mode == 1 && sof) begin
            m_frozen_frames++;
            if (m_frozen_frames >= freeze_len) begin
                m_mode = 0;
                m_inv_left = INVULN_FRAMES;
            end
        end
    endfunction

    task automatic check_out(string name, logic ep, logic el, int elv, logic ef, logic ei, logic eg);
        tests_run++;
        if (popBubble !== ep || arrowRetract !== ep || lifeLost !== el || lives !== LIVES_W'(elv) ||
            freeze !== ef || invulnerable !== ei || gameOver !== eg) begin
            tests_failed++;
            $display("FAIL %s: got pop=%0b ret=%0b lost=%0b lives=%0d frz=%0b inv=%0b go=%0b, want pop=%0b lost=%0b lives=%0d frz=%0b inv=%0b go=%0b",
                     name, popBubble, arrowRetract, lifeLost, lives, freeze, invulnerable, gameOver,
                     ep, el, elv, ef, ei, eg);
        end
    endtask

    task automatic check_model(string name);
        check_out(name, e_pop, e_lost, m_lives, m_mode != 0, m_inv_left != 0, m_mode == 2);
    endtask

    task automatic check_val(string name, int act, int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs and advance the model on the same edge
    task automatic drive(logic sof, logic bhc, logic ahb, logic rst);
        @(negedge clk);
        startOfFrame = sof; bubbleHitChar = bhc; arrowHitBubble = ahb; restart = rst;
        @(posedge clk);
        model_clock(sof, bhc, ahb, rst);
        #1;
    endtask

    task automatic step(logic sof, logic bhc, logic ahb, logic rst, string name);
        drive(sof, bhc, ahb, rst);
        check_model(name);
    endtask

    // Four-cycle frame with optional hit on its second cycle, ending in startOfFrame
    task automatic frame(logic bhc, logic ahb, string name);
        for (int i = 0; i < 3; i++) step(1'b0, bhc && i == 1, ahb && i == 1, 1'b0, name);
        step(1'b1, 1'b0, 1'b0, 1'b0, name);
    endtask

    typedef struct {
        logic sof, bhc, ahb, rst;
        logic pop, lost;
        int   lv;
        logic frz, inv, go;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{0,0,0,0, 0,0,3, 0,0,0};
        tbl[1]  = '{0,0,1,0, 0,0,3, 0,0,0};
        tbl[2]  = '{1,0,0,0, 1,0,3, 0,0,0};
        tbl[3]  = '{0,0,0,0, 0,0,3, 0,0,0};
        tbl[4]  = '{1,0,0,0, 0,0,3, 0,0,0};
        tbl[5]  = '{1,1,1,0, 1,1,2, 1,0,0};
        tbl[6]  = '{0,0,1,0, 0,0,2, 1,0,0};
        tbl[7]  = '{1,0,0,0, 0,0,2, 1,0,0};
        tbl[8]  = '{0,0,0,1, 0,0,3, 0,0,0};
        tbl[9]  = '{0,1,0,0, 0,0,3, 0,0,0};
        tbl[10] = '{1,0,0,1, 0,0,3, 0,0,0};
        tbl[11] = '{1,0,0,0, 0,0,3, 0,0,0};
        tbl[12] = '{0,1,0,0, 0,0,3, 0,0,0};
        tbl[13] = '{1,0,0,0, 0,1,2, 1,0,0};

        resetN = 1'b0;
        startOfFrame = 0; bubbleHitChar = 0; arrowHitBubble = 0; restart = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_out("in_reset", 0, 0, 3, 0, 0, 0);
        @(negedge clk) resetN = 1'b1;
        #1 check_out("after_reset", 0, 0, 3, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].sof, tbl[i].bhc, tbl[i].ahb, tbl[i].rst);
            check_out($sformatf("vec%0d", i), tbl[i].pop, tbl[i].lost, tbl[i].lv,
                      tbl[i].frz, tbl[i].inv, tbl[i].go);
        end

        // Arrow hit held for 5 cycles gives one pulse one cycle after the boundary
        step(0, 0, 0, 1, "arrow_restart");
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, "arrow_hold");
        step(0, 0, 0, 0, "arrow_idle");
        step(1, 0, 0, 0, "arrow_sof");
        check_val("arrow_pop", int'(popBubble), 1);
        check_val("arrow_retract", int'(arrowRetract), 1);
        step(0, 0, 0, 0, "arrow_after");
        check_val("arrow_pop_once", int'(popBubble), 0);
        check_val("arrow_lives", int'(lives), 3);

        // Life loss, freeze length, invulnerability window
        frame(1, 0, "loss_frame");
        check_val("loss_pulse", int'(lifeLost), 1);
        check_val("loss_lives", int'(lives), 2);
        check_val("loss_freeze", int'(freeze), 1);
        for (int f = 1; f <= 60; f++) begin
            frame(0, 0, "freeze_frames");
            if (f == 59) check_val("freeze_59", int'(freeze), 1);
        end
        check_val("freeze_end", int'(freeze), 0);
        check_val("invuln_start", int'(invulnerable), 1);
        for (int f = 0; f < 120; f++) frame(1, 0, "invuln_hits");
        check_val("invuln_lives", int'(lives), 2);
        frame(1, 0, "post_invuln_hit");
        check_val("post_invuln_lost", int'(lifeLost), 1);
        check_val("post_invuln_lives", int'(lives), 1);

        // Game over and restart
        for (int f = 0; f < 400 && !gameOver; f++) frame(1, 0, "to_gameover");
        check_val("gameover_flag", int'(gameOver), 1);
        check_val("gameover_lives", int'(lives), 0);
        check_val("gameover_freeze", int'(freeze), 1);
        for (int f = 0; f < 3; f++) frame(1, 1, "gameover_hits");
        step(0, 0, 0, 1, "gameover_restart");
        check_val("restart_lives", int'(lives), 3);
        check_val("restart_gameover", int'(gameOver), 0);

        // Asynchronous reset in the middle of a freeze
        frame(1, 0, "areset_loss");
        frame(0, 1, "areset_frozen");
        step(0, 0, 0, 0, "areset_idle");
        @(negedge clk);
        #2 resetN = 1'b0;
        model_reset();
        #1 check_out("areset_immediate", 0, 0, 3, 0, 0, 0);
        @(negedge clk) resetN = 1'b1;
        frame(0, 0, "areset_after");
        frame(0, 0, "areset_after");
        check_val("areset_no_pulse", int'(popBubble | lifeLost), 0);

        // Random traffic against the model
        step(0, 0, 0, 1, "rand_restart");
        begin
            int period, phase;
            period = 4; phase = 0;
            for (int c = 0; c < 4000; c++) begin
                logic sof;
                phase++;
                sof = (phase >= period);
                if (sof) begin
                    phase = 0;
                    period = int'($urandom_range(2, 6));
                end
                step(sof, $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 999) == 0, "random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
